// File: rtl/data_mem_dp.sv
// Dual-port data memory with a registered read port and a hardware init sequencer.
// Optional per-word even parity with error injection: define DATA_MEM_DP_PARITY_EN.
module data_mem_dp #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 W_EN,
  input  logic [ADDR_SIZE-1:0] W_ADDR,
  input  logic [DATA_SIZE-1:0] W_DATA,
  input  logic                 R_EN,
  input  logic [ADDR_SIZE-1:0] R_ADDR,
  output logic [DATA_SIZE-1:0] R_DATA,
  output logic                 R_VALID,
  input  logic                 INIT_REQ,
`ifdef DATA_MEM_DP_PARITY_EN
  input  logic                 ERR_INJ,
  output logic                 PAR_ERR,
`endif
  output logic                 BUSY
);

  localparam int unsigned MEM_SIZE = 1 << ADDR_SIZE;
`ifdef DATA_MEM_DP_PARITY_EN
  localparam int unsigned WORD_W = DATA_SIZE + 1;
`else
  localparam int unsigned WORD_W = DATA_SIZE;
`endif

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [DATA_SIZE-1:0] r_data_q, r_data_d;
  logic                 r_valid_q, r_valid_d;
`ifdef DATA_MEM_DP_PARITY_EN
  logic                 par_err_q, par_err_d;
`endif

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [WORD_W-1:0]    mem_wdata;
  logic [DATA_SIZE-1:0] init_data;
  logic [WORD_W-1:0]    init_word;
  logic [WORD_W-1:0]    wr_word;
  logic [WORD_W-1:0]    rd_word;

  // Array has no reset so it can map onto block RAM.
  logic [WORD_W-1:0]    mem_q [MEM_SIZE];

  assign init_data = (INIT_MODE == 0) ? '0 : DATA_SIZE'(cnt_q);

`ifdef DATA_MEM_DP_PARITY_EN
  assign init_word = {^init_data, init_data};
  assign wr_word   = {(^W_DATA) ^ ERR_INJ, W_DATA};
`else
  assign init_word = init_data;
  assign wr_word   = W_DATA;
`endif

  // Write-first: a same-address write on this edge bypasses the array.
  assign rd_word = (W_EN && (W_ADDR == R_ADDR)) ? wr_word : mem_q[R_ADDR];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = init_word;
`ifdef DATA_MEM_DP_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + ADDR_SIZE'(1);
        if (&cnt_q) state_d = ST_READY;
      end
      ST_READY: begin
        if (W_EN) begin
          mem_we    = 1'b1;
          mem_waddr = W_ADDR;
          mem_wdata = wr_word;
        end
        if (R_EN) begin
          r_valid_d = 1'b1;
          r_data_d  = rd_word[DATA_SIZE-1:0];
`ifdef DATA_MEM_DP_PARITY_EN
          par_err_d = ^rd_word;
`endif
        end
        if (INIT_REQ) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
`ifdef DATA_MEM_DP_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
`ifdef DATA_MEM_DP_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign R_DATA  = r_data_q;
  assign R_VALID = r_valid_q;
  assign BUSY    = busy_q;
`ifdef DATA_MEM_DP_PARITY_EN
  assign PAR_ERR = par_err_q;
`endif

endmodule

// File: tb/tb_data_mem_dp.sv
// Self-checking bench for data_mem_dp (default parameters) against an array model.
// Parity scenario is exercised when DATA_MEM_DP_PARITY_EN is defined.
module tb_data_mem_dp;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [DW-1:0] W_DATA;
  logic          R_EN;
  logic [AW-1:0] R_ADDR;
  logic [DW-1:0] R_DATA;
  logic          R_VALID;
  logic          INIT_REQ;
  logic          BUSY;
`ifdef DATA_MEM_DP_PARITY_EN
  logic          ERR_INJ;
  logic          PAR_ERR;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_rdata;

  always #5 clk = ~clk;

  data_mem_dp dut (
    .clk      (clk),
    .rstn     (rstn),
    .W_EN     (W_EN),
    .W_ADDR   (W_ADDR),
    .W_DATA   (W_DATA),
    .R_EN     (R_EN),
    .R_ADDR   (R_ADDR),
    .R_DATA   (R_DATA),
    .R_VALID  (R_VALID),
    .INIT_REQ (INIT_REQ),
`ifdef DATA_MEM_DP_PARITY_EN
    .ERR_INJ  (ERR_INJ),
    .PAR_ERR  (PAR_ERR),
`endif
    .BUSY     (BUSY)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Init pattern 1: word i holds i, zero-extended to 8 bits.
  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = DW'(i);
  endfunction

  task automatic idle();
    W_EN = 1'b0; W_ADDR = '0; W_DATA = '0;
    R_EN = 1'b0; R_ADDR = '0; INIT_REQ = 1'b0;
`ifdef DATA_MEM_DP_PARITY_EN
    ERR_INJ = 1'b0;
`endif
  endtask

  // Counts negedge samples with BUSY high, starting at the current negedge.
  task automatic count_busy(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", BUSY); end
    n_checks++; if (R_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", R_VALID); end
    n_checks++; if (R_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", R_DATA); end
    exp_rdata = 8'h00;
  endtask

  task automatic test_init_busy();
    int n;
    rstn = 1'b1;
    count_busy(n);
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL init_busy_cycles: got %0d expected 32", n); end
    model_init();
  endtask

  // Pipelined read of every address, one per cycle.
  task automatic test_full_readback();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        R_EN = 1'b1; R_ADDR = AW'(i);
      end else begin
        R_EN = 1'b0;
      end
      @(negedge clk);
      if (i < DEPTH) begin
        n_checks++; if (R_VALID !== 1'b1 || R_DATA !== model[i]) begin
          n_fail++; $display("FAIL readback[%0d]: got v=%b d=%h expected v=1 d=%h", i, R_VALID, R_DATA, model[i]);
        end
        exp_rdata = model[i];
      end
    end
    n_checks++; if (R_VALID !== 1'b0) begin n_fail++; $display("FAIL readback_end_valid: got %b expected 0", R_VALID); end
  endtask

  task automatic test_init_pattern();
    logic [AW-1:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
    for (int k = 0; k < 3; k++) begin
      R_EN = 1'b1; R_ADDR = addrs[k];
      @(negedge clk);
      R_EN = 1'b0;
      n_checks++; if (R_VALID !== 1'b1 || R_DATA !== DW'(addrs[k])) begin
        n_fail++; $display("FAIL init_read[%0d]: got v=%b d=%h expected v=1 d=%h", addrs[k], R_VALID, R_DATA, DW'(addrs[k]));
      end
      @(negedge clk);
      n_checks++; if (R_VALID !== 1'b0) begin n_fail++; $display("FAIL init_read_pulse: got %b expected 0", R_VALID); end
    end
    exp_rdata = 8'h1F;
    test_full_readback();
  endtask

  task automatic test_write_read();
    W_EN = 1'b1; W_ADDR = 5'd7; W_DATA = 8'hA5;
    @(negedge clk);
    model[7] = 8'hA5;
    W_EN = 1'b0; R_EN = 1'b1; R_ADDR = 5'd7;
    @(negedge clk);
    R_EN = 1'b0;
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'hA5) begin
      n_fail++; $display("FAIL write_read: got v=%b d=%h expected v=1 d=a5", R_VALID, R_DATA);
    end
    @(negedge clk);
    n_checks++; if (R_VALID !== 1'b0 || R_DATA !== 8'hA5) begin
      n_fail++; $display("FAIL write_read_hold: got v=%b d=%h expected v=0 d=a5", R_VALID, R_DATA);
    end
    exp_rdata = 8'hA5;
  endtask

  task automatic test_same_edge();
    W_EN = 1'b1; W_ADDR = 5'd3; W_DATA = 8'h3C; R_EN = 1'b1; R_ADDR = 5'd3;
    @(negedge clk);
    model[3] = 8'h3C;
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'h3C) begin
      n_fail++; $display("FAIL same_addr_write_first: got v=%b d=%h expected v=1 d=3c", R_VALID, R_DATA);
    end
    R_ADDR = 5'd4;
    @(negedge clk);
    idle();
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'h04) begin
      n_fail++; $display("FAIL diff_addr_same_edge: got v=%b d=%h expected v=1 d=04", R_VALID, R_DATA);
    end
    exp_rdata = 8'h04;
    @(negedge clk);
  endtask

  // Random concurrent traffic; writes land before a same-edge read observes them.
  task automatic test_random();
    logic exp_valid;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic we, re;
    exp_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = AW'($urandom);
      wd = DW'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      W_EN = we; W_ADDR = wa; W_DATA = wd; R_EN = re; R_ADDR = ra;
      if (we) model[wa] = wd;
      if (re) exp_rdata = model[ra];
      exp_valid = re;
      @(negedge clk);
      n_checks++; if (R_VALID !== exp_valid || R_DATA !== exp_rdata) begin
        n_fail++; $display("FAIL random[%0d]: got v=%b d=%h expected v=%b d=%h", c, R_VALID, R_DATA, exp_valid, exp_rdata);
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_init_req();
    int n;
    W_EN = 1'b1; W_ADDR = 5'd9; W_DATA = 8'hFF;
    @(negedge clk);
    model[9] = 8'hFF;
    W_EN = 1'b0; INIT_REQ = 1'b1; R_EN = 1'b1; R_ADDR = 5'd9;
    @(negedge clk);
    INIT_REQ = 1'b0; R_EN = 1'b0;
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'hFF) begin
      n_fail++; $display("FAIL init_req_read_serviced: got v=%b d=%h expected v=1 d=ff", R_VALID, R_DATA);
    end
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL init_req_busy: got %b expected 1", BUSY); end
    n = 1;
    while (n < 200) begin
      W_EN = 1'($urandom_range(0, 1)); W_ADDR = AW'($urandom); W_DATA = DW'($urandom);
      R_EN = 1'($urandom_range(0, 1)); R_ADDR = AW'($urandom); INIT_REQ = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (BUSY !== 1'b1) break;
      n++;
      n_checks++; if (R_VALID !== 1'b0 || R_DATA !== 8'hFF) begin
        n_fail++; $display("FAIL busy_ignores_req[%0d]: got v=%b d=%h expected v=0 d=ff", n, R_VALID, R_DATA);
      end
    end
    idle();
    n_checks++; if (R_VALID !== 1'b0) begin n_fail++; $display("FAIL busy_last_ignored: got %b expected 0", R_VALID); end
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL init_req_busy_cycles: got %0d expected 32", n); end
    model_init();
    R_EN = 1'b1; R_ADDR = 5'd9;
    @(negedge clk);
    R_EN = 1'b0;
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'h09) begin
      n_fail++; $display("FAIL reinit_addr9: got v=%b d=%h expected v=1 d=09", R_VALID, R_DATA);
    end
    exp_rdata = 8'h09;
    test_full_readback();
  endtask

  task automatic test_reset_mid_op();
    int n;
    R_EN = 1'b1; R_ADDR = 5'd31;
    @(negedge clk);
    R_EN = 1'b0;
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'h1F) begin
      n_fail++; $display("FAIL pre_reset_read: got v=%b d=%h expected v=1 d=1f", R_VALID, R_DATA);
    end
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (R_VALID !== 1'b0 || R_DATA !== 8'h00 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_read: got v=%b d=%h b=%b expected v=0 d=00 b=1", R_VALID, R_DATA, BUSY);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    count_busy(n);
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL reset_busy_cycles: got %0d expected 32", n); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (R_VALID !== 1'b0 || R_DATA !== 8'h00 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_init: got v=%b d=%h b=%b expected v=0 d=00 b=1", R_VALID, R_DATA, BUSY);
    end
    @(negedge clk);
    rstn = 1'b1;
    count_busy(n);
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL reinit_after_reset_cycles: got %0d expected 32", n); end
    model_init();
    exp_rdata = 8'h00;
    test_full_readback();
  endtask

`ifdef DATA_MEM_DP_PARITY_EN
  task automatic test_parity();
    logic [1:0] inj_seq [3];
    inj_seq[0] = 2'b01; inj_seq[1] = 2'b00; inj_seq[2] = 2'b11;
    // bit0: ERR_INJ, bit1: same-edge bypass read
    for (int k = 0; k < 3; k++) begin
      W_EN = 1'b1; W_ADDR = 5'd2; W_DATA = 8'h12; ERR_INJ = inj_seq[k][0];
      R_EN = inj_seq[k][1]; R_ADDR = 5'd2;
      @(negedge clk);
      if (!inj_seq[k][1]) begin
        W_EN = 1'b0; ERR_INJ = 1'b0; R_EN = 1'b1;
        @(negedge clk);
      end
      idle();
      n_checks++; if (R_VALID !== 1'b1 || R_DATA !== 8'h12 || PAR_ERR !== inj_seq[k][0]) begin
        n_fail++; $display("FAIL parity[%0d]: got v=%b d=%h p=%b expected v=1 d=12 p=%b", k, R_VALID, R_DATA, PAR_ERR, inj_seq[k][0]);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    @(negedge clk);
    test_init_busy();
    test_init_pattern();
    test_write_read();
    test_same_edge();
    test_random();
    test_init_req();
    test_reset_mid_op();
`ifdef DATA_MEM_DP_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
